// File: rtl/spi_reg_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : spi_reg_slave
// Description : SPI mode-0 slave exposing a bank of 8-bit control registers.
//               Frames are 16 bits, MSB first:
//                 [15] R/W (1 = write), [14:8] address, [7:0] data.
//               The SPI pins are synchronised into the clk domain. A frame FSM
//               then decodes each frame. A committed write pulses wr_strobe.
//               A read returns the addressed register on MISO during the data
//               byte. A frame that aborts early pulses frame_err.
// Ports       : clk        system clock
//               rst        asynchronous reset, active-high
//               SCLK       SPI clock from host (async, <= clk/8)
//               SSEL       SPI select, active-low (async)
//               MOSI       SPI data in, MSB first
//               MISO       SPI data out, MSB first
//               regs_flat  register bank, reg i at [8*i+7:8*i]
//               wr_strobe  one-clk pulse per committed write
//               wr_addr    address of last committed write
//               frame_err  one-clk pulse when a frame aborts before 16 bits
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_slave #(
  parameter int          NUM_REGS  = 8,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SCLK,
  input  logic                  SSEL,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr,
  output logic                  frame_err
);

  localparam logic [7:0] c_num_regs = 8'(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // --------------------------------------------------------------------------
  // Pin synchronisers and edge detection
  // --------------------------------------------------------------------------
  logic r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic r_ssel_s1, r_ssel_s2, r_ssel_d;
  logic r_mosi_s1, r_mosi_s2;

  // The SSEL chain resets to 0, which means "selected". A frame already in
  // progress when rst releases therefore shows no falling edge. The slave
  // waits for a full high-then-low SSEL cycle before it decodes anything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_ssel_s1 <= 1'b0;
      r_ssel_s2 <= 1'b0;
      r_ssel_d  <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sclk_s1 <= SCLK;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_ssel_s1 <= SSEL;
      r_ssel_s2 <= r_ssel_s1;
      r_ssel_d  <= r_ssel_s2;
      r_mosi_s1 <= MOSI;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  logic w_sclk_rise, w_sclk_fall, w_ssel_rise, w_ssel_fall;
  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
  assign w_ssel_rise = r_ssel_s2 & ~r_ssel_d;
  assign w_ssel_fall = ~r_ssel_s2 & r_ssel_d;

  // --------------------------------------------------------------------------
  // Frame datapath registers
  // --------------------------------------------------------------------------
  logic [3:0] r_bit_cnt;
  logic [7:0] r_rx;
  logic [7:0] r_tx;
  logic       r_rw;
  logic [6:0] r_addr;
  logic       r_first_fall;
  logic [7:0] r_regs [NUM_REGS];
  logic       r_wr_strobe;
  logic [6:0] r_wr_addr;
  logic       r_frame_err;

  logic       w_addr_ok;
  logic [7:0] w_wr_data;
  logic [7:0] w_rd_data;

  assign w_addr_ok = ({1'b0, r_addr} < c_num_regs);
  // The last data bit is still in the synchroniser on the 16th rise.
  assign w_wr_data = {r_rx[6:0], r_mosi_s2};

  always_comb begin
    w_rd_data = 8'h00;
    if (!r_rw && w_addr_ok) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (r_addr == 7'(k)) begin
          w_rd_data = r_regs[k];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  logic w_clr_cnt, w_shift_rx, w_latch_cmd, w_load_tx, w_shift_tx;
  logic w_commit, w_abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_cnt   = 1'b0;
    w_shift_rx  = 1'b0;
    w_latch_cmd = 1'b0;
    w_load_tx   = 1'b0;
    w_shift_tx  = 1'b0;
    w_commit    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ssel_fall) begin
          w_state_nxt = ST_CMD;
          w_clr_cnt   = 1'b1;
        end
      end
      ST_CMD: begin
        if (w_ssel_rise) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_sclk_rise) begin
          w_shift_rx = 1'b1;
          if (r_bit_cnt == 4'd7) begin
            w_latch_cmd = 1'b1;
            w_state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        // The abort check comes first, so a commit and an error never
        // occur in the same clk.
        if (w_ssel_rise) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          // The first fall in DATA is the 8th SCLK fall of the frame.
          // Loading there puts the read MSB on MISO before the 9th rise.
          if (w_sclk_fall) begin
            if (r_first_fall) begin
              w_load_tx = 1'b1;
            end else begin
              w_shift_tx = 1'b1;
            end
          end
          if (w_sclk_rise) begin
            w_shift_rx = 1'b1;
            if (r_bit_cnt == 4'd15) begin
              w_state_nxt = ST_DONE;
              w_commit    = r_rw & w_addr_ok;
            end
          end
        end
      end
      ST_DONE: begin
        if (w_ssel_rise) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath updates
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt    <= 4'd0;
      r_rx         <= 8'h00;
      r_tx         <= 8'h00;
      r_rw         <= 1'b0;
      r_addr       <= 7'd0;
      r_first_fall <= 1'b0;
      r_wr_strobe  <= 1'b0;
      r_wr_addr    <= 7'd0;
      r_frame_err  <= 1'b0;
    end else begin
      if (w_clr_cnt) begin
        r_bit_cnt <= 4'd0;
      end else if (w_shift_rx) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end

      if (w_shift_rx) begin
        r_rx <= {r_rx[6:0], r_mosi_s2};
      end

      if (w_latch_cmd) begin
        r_rw         <= r_rx[6];
        r_addr       <= {r_rx[5:0], r_mosi_s2};
        r_first_fall <= 1'b1;
      end

      if (w_clr_cnt) begin
        r_tx <= 8'h00;
      end else if (w_load_tx) begin
        r_tx         <= w_rd_data;
        r_first_fall <= 1'b0;
      end else if (w_shift_tx) begin
        r_tx <= {r_tx[6:0], 1'b0};
      end

      r_wr_strobe <= w_commit;
      r_frame_err <= w_abort;
      if (w_commit) begin
        r_wr_addr <= r_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        r_regs[k] <= RESET_VAL;
      end
    end else if (w_commit) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (r_addr == 7'(k)) begin
          r_regs[k] <= w_wr_data;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
      assign regs_flat[8*i +: 8] = r_regs[i];
    end
  endgenerate

  assign MISO      = ((r_state == ST_DATA) && !r_ssel_s2) ? r_tx[7] : 1'b0;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spi_reg_slave
// Description : Self-checking bench for spi_reg_slave. A reference copy of the
//               register bank is kept, expected writes and read bytes are
//               queued as frames are driven, and they are compared when the
//               DUT produces wr_strobe pulses or MISO bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_slave;

  localparam int NUM_REGS = 8;
  localparam int HALF     = 80;   // SCLK half period in ns (clk = 10 ns)

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  SCLK = 1'b0;
  logic                  SSEL = 1'b1;
  logic                  MOSI = 1'b0;
  logic                  MISO;
  logic [NUM_REGS*8-1:0] regs_flat;
  logic                  wr_strobe;
  logic [6:0]            wr_addr;
  logic                  frame_err;

  spi_reg_slave #(.NUM_REGS(NUM_REGS), .RESET_VAL(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .SCLK      (SCLK),
    .SSEL      (SSEL),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .regs_flat (regs_flat),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_strobe = 0;
  int n_ferr   = 0;

  logic [7:0]  model [NUM_REGS];
  logic [14:0] q_wr [$];   // {addr[6:0], data[7:0]}
  logic [7:0]  q_rd [$];

  // ---------------- strobe / error monitor (scoreboard pop side) ------------
  logic prev_strobe = 1'b0;
  logic prev_ferr   = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_strobe) begin
        logic [14:0] e;
        n_strobe++;
        n_checks++;
        if (q_wr.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: wr_addr=%0d, no write expected", wr_addr);
        end else begin
          e = q_wr.pop_front();
          if (wr_addr !== e[14:8] || regs_flat[8*e[14:8] +: 8] !== e[7:0]) begin
            n_fail++;
            $display("FAIL strobe_write: got addr=%0d data=%h, want addr=%0d data=%h",
                     wr_addr, regs_flat[8*wr_addr +: 8], e[14:8], e[7:0]);
          end
        end
        n_checks++;
        if (prev_strobe !== 1'b0 || frame_err !== 1'b0) begin
          n_fail++;
          $display("FAIL strobe_width: prev_strobe=%b frame_err=%b, want 0 0",
                   prev_strobe, frame_err);
        end
      end
      if (frame_err) begin
        n_ferr++;
        n_checks++;
        if (prev_ferr !== 1'b0) begin
          n_fail++;
          $display("FAIL ferr_width: frame_err high on consecutive clks, want 1 clk");
        end
      end
    end
    prev_strobe = wr_strobe;
    prev_ferr   = frame_err;
  end

  // ---------------- SPI host ------------------------------------------------
  task automatic spi_xfer(input logic [15:0] f, input int nbits, input bit end_ssel,
                          output logic [7:0] rd, output int cmd_miso_hi);
    rd = 8'h00;
    cmd_miso_hi = 0;
    SSEL = 1'b0;
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      MOSI = f[15-i];
      #(HALF);
      if (i >= 8) rd[15-i] = MISO;
      else if (MISO !== 1'b0) cmd_miso_hi++;
      SCLK = 1'b1;
      #(HALF);
      SCLK = 1'b0;
    end
    MOSI = 1'b0;
    #(HALF);
    if (end_ssel) SSEL = 1'b1;
    #(4*HALF);
  endtask

  // Full frame; queues expected write/read results.
  task automatic frame(input logic [7:0] cmd, input logic [7:0] data, output logic [7:0] rd);
    int hi;
    if (cmd[7] && cmd[6:0] < NUM_REGS) begin
      q_wr.push_back({cmd[6:0], data});
      model[cmd[6:0]] = data;
    end
    if (!cmd[7]) q_rd.push_back((cmd[6:0] < NUM_REGS) ? model[cmd[6:0]] : 8'h00);
    spi_xfer({cmd, data}, 16, 1'b1, rd, hi);
    n_checks++;
    if (hi != 0) begin
      n_fail++;
      $display("FAIL miso_cmd_phase: MISO high %0d times during command byte, want 0", hi);
    end
    if (!cmd[7]) begin
      logic [7:0] e;
      e = q_rd.pop_front();
      n_checks++;
      if (rd !== e) begin
        n_fail++;
        $display("FAIL read_data: addr=%0d got %h, want %h", cmd[6:0], rd, e);
      end
    end
  endtask

  task automatic check_regs(input string name);
    n_checks++;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (regs_flat[8*k +: 8] !== model[k]) begin
        n_fail++;
        $display("FAIL %s: reg%0d got %h, want %h", name, k, regs_flat[8*k +: 8], model[k]);
        break;
      end
    end
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    for (int k = 0; k < NUM_REGS; k++) model[k] = 8'h00;
    repeat (3) @(negedge clk);
    check_regs("reset_regs");
    n_checks++;
    if ({MISO, wr_strobe, wr_addr, frame_err} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: MISO=%b strobe=%b addr=%0d ferr=%b, want all 0",
               MISO, wr_strobe, wr_addr, frame_err);
    end
    rst = 1'b0;
    #(4*HALF);
  endtask

  task automatic test_write();
    logic [7:0] rd;
    int s0, e0;
    s0 = n_strobe; e0 = n_ferr;
    frame(8'h83, 8'h5A, rd);
    n_checks++;
    if (n_strobe - s0 != 1 || n_ferr != e0 || wr_addr !== 7'd3) begin
      n_fail++;
      $display("FAIL write_reg3: strobes=%0d errs=%0d addr=%0d, want 1 0 3",
               n_strobe - s0, n_ferr - e0, wr_addr);
    end
    check_regs("write_reg3_bank");
  endtask

  task automatic test_read();
    logic [7:0] rd;
    int s0;
    s0 = n_strobe;
    frame(8'h03, 8'h00, rd);
    n_checks++;
    if (n_strobe != s0 || rd !== 8'h5A) begin
      n_fail++;
      $display("FAIL read_reg3: strobes=%0d data=%h, want 0 5a", n_strobe - s0, rd);
    end
    check_regs("read_reg3_bank");
    frame(8'h07, 8'h00, rd);   // untouched register reads its reset value
  endtask

  task automatic test_out_of_range();
    logic [7:0] rd;
    int s0;
    s0 = n_strobe;
    frame(8'h89, 8'hFF, rd);
    n_checks++;
    if (n_strobe != s0) begin
      n_fail++;
      $display("FAIL oor_write: strobes=%0d, want 0", n_strobe - s0);
    end
    check_regs("oor_write_bank");
    frame(8'h09, 8'h00, rd);
  endtask

  task automatic test_abort();
    logic [7:0] rd;
    int hi, s0, e0;
    s0 = n_strobe; e0 = n_ferr;
    spi_xfer({8'h84, 8'hC3}, 10, 1'b1, rd, hi);
    n_checks++;
    if (n_ferr - e0 != 1 || n_strobe != s0) begin
      n_fail++;
      $display("FAIL abort: errs=%0d strobes=%0d, want 1 0", n_ferr - e0, n_strobe - s0);
    end
    check_regs("abort_bank");
    frame(8'h81, 8'h11, rd);
    n_checks++;
    if (n_strobe - s0 != 1 || n_ferr - e0 != 1) begin
      n_fail++;
      $display("FAIL after_abort: strobes=%0d errs=%0d, want 1 1", n_strobe - s0, n_ferr - e0);
    end
    check_regs("after_abort_bank");
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    int s0;
    s0 = n_strobe;
    frame(8'h80, 8'h01, rd);
    frame(8'h87, 8'h7E, rd);
    n_checks++;
    if (n_strobe - s0 != 2) begin
      n_fail++;
      $display("FAIL back_to_back: strobes=%0d, want 2", n_strobe - s0);
    end
    check_regs("back_to_back_bank");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] rd;
    int hi, s0;
    spi_xfer({8'h85, 8'hA5}, 12, 1'b0, rd, hi);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < NUM_REGS; k++) model[k] = 8'h00;
    repeat (2) @(negedge clk);
    check_regs("midrst_regs");
    n_checks++;
    if (MISO !== 1'b0 || wr_strobe !== 1'b0 || wr_addr !== 7'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: MISO=%b strobe=%b addr=%0d, want 0 0 0",
               MISO, wr_strobe, wr_addr);
    end
    rst = 1'b0;
    s0 = n_strobe;
    // Host finishes the old frame with SSEL still low: it must be ignored.
    for (int i = 0; i < 4; i++) begin
      MOSI = 1'b1; #(HALF); SCLK = 1'b1; #(HALF); SCLK = 1'b0;
    end
    #(HALF);
    SSEL = 1'b1;
    #(4*HALF);
    n_checks++;
    if (n_strobe != s0) begin
      n_fail++;
      $display("FAIL midrst_tail: strobes=%0d, want 0", n_strobe - s0);
    end
    check_regs("midrst_tail_bank");
    frame(8'h82, 8'h33, rd);
    frame(8'h02, 8'h00, rd);
    check_regs("midrst_next_bank");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_out_of_range();
    test_abort();
    test_back_to_back();
    test_reset_mid_frame();
    repeat (10) @(negedge clk);
    n_checks++;
    if (q_wr.size() != 0) begin
      n_fail++;
      $display("FAIL pending_writes: %0d expected writes never strobed, want 0", q_wr.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(2_000_000);
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
